// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// The master side is the sequencer. It samples the lock and restart inputs and drives the PLL
// reset, the downstream reset, and the status outputs. The slave side is the environment, that
// is the PLL and the user logic.
interface pll_lock_seq_if #(
  parameter int RETRY_W = 2
);
  logic               pll_lock_i;
  logic               restart_i;
  logic               pll_reset_o;
  logic               user_rst_n_o;
  logic               pll_ready_o;
  logic               fault_o;
  logic [RETRY_W-1:0] retry_cnt_o;

  modport master (
    input  pll_lock_i, restart_i,
    output pll_reset_o, user_rst_n_o, pll_ready_o, fault_o, retry_cnt_o
  );

  modport slave (
    output pll_lock_i, restart_i,
    input  pll_reset_o, user_rst_n_o, pll_ready_o, fault_o, retry_cnt_o
  );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer, clocked from the PLL reference clock.
// Behaviour:
//   - Holds the PLL in reset for RST_CYCLES cycles.
//   - Waits up to LOCK_TIMEOUT cycles for the synchronised lock signal.
//   - Requires STABLE_CYCLES consecutive locked cycles before it releases the downstream reset.
//   - Retries a failed lock up to MAX_RETRY times, then parks in FAULT.
// Optional feature (macro PLL_LOSS_RECOVER_EN):
//   - Defined: a lock loss in RUN triggers an automatic re-lock with the retry count cleared.
//   - Undefined (default): a lock loss in RUN is treated as fatal and goes to FAULT.
module pll_lock_seq #(
  parameter int RST_CYCLES    = 64,
  parameter int LOCK_TIMEOUT  = 70000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3,
  parameter int RETRY_W       = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  pll_lock_seq_if.master bus
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sync1_q, sync2_q;
  logic               lock_s;
  logic               pll_reset_q;
  logic               user_rst_n_q;
  logic               pll_ready_q;
  logic               fault_q;

  // Two-flop synchroniser: bring the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample old values, forming a real
      // two-stage chain; blocking here would collapse it into a single flop.
      sync1_q <= bus.pll_lock_i;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  // Next-state logic: sequencing, lock timeout, retry accounting and restart priority.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path leaves it
    // unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;

    if (bus.restart_i) begin
      state_d = ST_RST_HOLD;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RST_HOLD: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (lock_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q < RETRY_LIMIT) begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_RST_HOLD;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s)                   state_d = ST_WAIT_LOCK;
          else if (cnt_q == STABLE_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
`ifdef PLL_LOSS_RECOVER_EN
            state_d = ST_RST_HOLD;
            retry_d = '0;
`else
            state_d = ST_FAULT;
`endif
          end
        end
        ST_FAULT: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_RST_HOLD;
        end
      endcase
    end

    // A single counter serves every timed state, so it restarts whenever the state changes.
    // A restart while already in RST_HOLD must also begin a fresh hold period.
    if (bus.restart_i || (state_d != state_q)) cnt_d = '0;
  end

  // FSM registers. The outputs are decoded from the next state, so they are registered and
  // change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RST_HOLD;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_reset_q  <= 1'b1;
      user_rst_n_q <= 1'b0;
      pll_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_reset_q  <= (state_d == ST_RST_HOLD) || (state_d == ST_FAULT);
      user_rst_n_q <= (state_d == ST_RUN);
      pll_ready_q  <= (state_d == ST_RUN);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus.pll_reset_o  = pll_reset_q;
  assign bus.user_rst_n_o = user_rst_n_q;
  assign bus.pll_ready_o  = pll_ready_q;
  assign bus.fault_o      = fault_q;
  assign bus.retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Self-checking bench for pll_lock_seq.
// It runs three phases:
//   - A table of directed segments with hand-derived expected outputs.
//   - A hand-written retry/relock sequence.
//   - Randomised lock, restart and reset traffic checked against a behavioural model.
// Expected values follow PLL_LOSS_RECOVER_EN in the same way as the design.
module tb_pll_lock_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;
  localparam int RETRY_W       = 2;

  logic clk = 1'b0;
  logic rst_n;

  pll_lock_seq_if #(.RETRY_W(RETRY_W)) bus ();

  pll_lock_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .RETRY_W      (RETRY_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output vector layout: {pll_reset, user_rst_n, pll_ready, fault, retry_cnt[1:0]}.
  function automatic logic [5:0] outs(input bit pr, input bit ur, input bit rd, input bit ft,
                                      input int rt);
    return {pr, ur, rd, ft, 2'(rt)};
  endfunction

  function automatic logic [5:0] dut_outs();
    return {bus.pll_reset_o, bus.user_rst_n_o, bus.pll_ready_o, bus.fault_o, bus.retry_cnt_o};
  endfunction

  // ---------------------------------------------------------------------------------------
  // Behavioural reference model.
  //   - It keeps a phase name and the number of cycles spent in that phase.
  //   - Phase changes follow the rules stated as elapsed-cycle counts.
  //   - The synchroniser is modelled as a 2-deep delay line.
  // ---------------------------------------------------------------------------------------
  typedef enum {M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAULT} mphase_e;
  mphase_e m_phase   = M_HOLD;
  int      m_elapsed = 0;
  int      m_retry   = 0;
  bit      m_dly[2]  = '{1'b0, 1'b0};

  task automatic model_edge(input bit r, input bit lock_v, input bit rs);
    bit ls;
    if (!r) begin
      m_phase = M_HOLD; m_elapsed = 0; m_retry = 0; m_dly = '{1'b0, 1'b0};
      return;
    end
    ls       = m_dly[1];
    m_dly[1] = m_dly[0];
    m_dly[0] = lock_v;
    if (rs) begin
      m_phase = M_HOLD; m_elapsed = 0; m_retry = 0;
      return;
    end
    case (m_phase)
      M_HOLD: begin
        m_elapsed++;
        if (m_elapsed == RST_CYCLES) begin m_phase = M_WAIT; m_elapsed = 0; end
      end
      M_WAIT: begin
        if (ls) begin
          m_phase = M_STABLE; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == LOCK_TIMEOUT) begin
            m_elapsed = 0;
            if (m_retry < MAX_RETRY) begin m_retry++; m_phase = M_HOLD; end
            else m_phase = M_FAULT;
          end
        end
      end
      M_STABLE: begin
        if (!ls) begin
          m_phase = M_WAIT; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == STABLE_CYCLES) begin m_phase = M_RUN; m_elapsed = 0; end
        end
      end
      M_RUN: begin
        if (!ls) begin
`ifdef PLL_LOSS_RECOVER_EN
          m_phase = M_HOLD; m_retry = 0;
`else
          m_phase = M_FAULT;
`endif
          m_elapsed = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [5:0] model_outs();
    return outs(m_phase inside {M_HOLD, M_FAULT}, m_phase == M_RUN, m_phase == M_RUN,
                m_phase == M_FAULT, m_retry);
  endfunction

  // One clock: drive the inputs, step the model on the edge, then return at the negative edge
  // so the outputs are sampled away from the active edge.
  task automatic step(input bit r, input bit l, input bit rs);
    rst_n          = r;
    bus.pll_lock_i = l;
    bus.restart_i  = rs;
    @(posedge clk);
    model_edge(r, l, rs);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------------------
  // Directed segment table.
  //   - Each row applies the same inputs for n cycles, then checks the outputs.
  // ---------------------------------------------------------------------------------------
  typedef struct {
    string      name;
    bit         rst_n;
    bit         lock;
    bit         restart;
    int         n;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input bit r, input bit l, input bit rs,
                              input int n, input logic [5:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.lock = l; v.restart = rs; v.n = n; v.exp = e;
    return v;
  endfunction

  initial begin
    int n;
    int highs;
    int rises;
    bit prev;
    int seg_left;
    bit lvl;
    bit r_rand;
    bit rs_rand;

    rst_n          = 1'b0;
    bus.pll_lock_i = 1'b0;
    bus.restart_i  = 1'b0;

    // Nominal bring-up.
    vecs.push_back(mk("reset_values",   0, 0, 0, 2,  outs(1, 0, 0, 0, 0)));
    vecs.push_back(mk("hold_3_cycles",  1, 0, 0, 3,  outs(1, 0, 0, 0, 0)));
    vecs.push_back(mk("hold_ends_at_4", 1, 0, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("sync_latency",   1, 1, 0, 2,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("stable_counting",1, 1, 0, 8,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("run_entered",    1, 1, 0, 1,  outs(0, 1, 1, 0, 0)));
    // Lock loss in RUN: a one-cycle dip shows up on the third edge.
    vecs.push_back(mk("loss_edge1",     1, 0, 0, 1,  outs(0, 1, 1, 0, 0)));
    vecs.push_back(mk("loss_edge2",     1, 1, 0, 1,  outs(0, 1, 1, 0, 0)));
`ifdef PLL_LOSS_RECOVER_EN
    vecs.push_back(mk("loss_edge3",     1, 1, 0, 1,  outs(1, 0, 0, 0, 0)));
    vecs.push_back(mk("loss_relocking", 1, 1, 0, 10, outs(0, 0, 0, 0, 0)));
`else
    vecs.push_back(mk("loss_edge3",     1, 1, 0, 1,  outs(1, 0, 0, 1, 0)));
    vecs.push_back(mk("loss_sticky",    1, 1, 0, 10, outs(1, 0, 0, 1, 0)));
`endif
    // Timeouts, retries and fault.
    vecs.push_back(mk("restart",        1, 1, 1, 1,  outs(1, 0, 0, 0, 0)));
    vecs.push_back(mk("wait_lock_0",    1, 0, 0, 4,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("before_timeout", 1, 0, 0, 19, outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("timeout_1",      1, 0, 0, 1,  outs(1, 0, 0, 0, 1)));
    vecs.push_back(mk("wait_lock_1",    1, 0, 0, 4,  outs(0, 0, 0, 0, 1)));
    vecs.push_back(mk("timeout_2",      1, 0, 0, 20, outs(1, 0, 0, 0, 2)));
    vecs.push_back(mk("fault_entered",  1, 0, 0, 24, outs(1, 0, 0, 1, 2)));
    vecs.push_back(mk("fault_sticky",   1, 0, 0, 5,  outs(1, 0, 0, 1, 2)));
    vecs.push_back(mk("fault_restart",  1, 0, 1, 1,  outs(1, 0, 0, 0, 0)));
    // Glitch during STABLE: 5 high, 1 low, then high.
    vecs.push_back(mk("glitch_wait",    1, 0, 0, 4,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_hi_a",    1, 1, 0, 2,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_hi_b",    1, 1, 0, 3,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_lo",      1, 0, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_rehi_a",  1, 1, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_back",    1, 1, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_restab",  1, 1, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_no_run",  1, 1, 0, 7,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("glitch_run",     1, 1, 0, 1,  outs(0, 1, 1, 0, 0)));
    // Reset in RUN and in STABLE.
    vecs.push_back(mk("reset_in_run",   0, 1, 0, 1,  outs(1, 0, 0, 0, 0)));
    vecs.push_back(mk("rerun_hold",     1, 1, 0, 4,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("rerun_stable",   1, 1, 0, 1,  outs(0, 0, 0, 0, 0)));
    vecs.push_back(mk("reset_in_stable",0, 1, 0, 1,  outs(1, 0, 0, 0, 0)));

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) step(vecs[i].rst_n, vecs[i].lock, vecs[i].restart);
      check(vecs[i].name, 32'(dut_outs()), 32'(vecs[i].exp));
    end

    // Retry sequence:
    //   - Hold lock low for 60 cycles from a restart. This gives three 4-cycle reset pulses
    //     20 cycles apart.
    //   - Then raise lock and expect RUN with retry count 2.
    highs = 0; rises = 0; prev = 1'b0;
    step(1, 0, 1);
    for (int i = 0; i < 60; i++) begin
      if (bus.pll_reset_o && !prev) rises++;
      if (bus.pll_reset_o) highs++;
      prev = bus.pll_reset_o;
      step(1, 0, 0);
    end
    check("retry_pulse_count", 32'(rises), 32'd3);
    check("retry_pulse_cycles", 32'(highs), 32'd12);
    check("retry_cnt_before_lock", 32'(bus.retry_cnt_o), 32'd2);
    n = 0;
    while (!bus.pll_ready_o && n < 40) begin
      step(1, 1, 0);
      n++;
    end
    check("relock_ready", 32'(bus.pll_ready_o), 32'd1);
    check("relock_latency", 32'(n), 32'd11);
    check("relock_outputs", 32'(dut_outs()), 32'(outs(0, 1, 1, 0, 2)));

    // Randomised traffic against the model:
    //   - Alternating lock segments of random length.
    //   - Rare restart pulses and resets.
    seg_left = 0;
    lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_rand  = ($urandom_range(0, 399) != 0);
      rs_rand = ($urandom_range(0, 119) == 0);
      if (seg_left == 0) begin
        lvl      = ~lvl;
        seg_left = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      end
      seg_left--;
      step(r_rand, lvl, rs_rand);
      check("random_vs_model", 32'(dut_outs()), 32'(model_outs()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
